// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue initiator.
// FSM states, run modes, operation kinds, LFSR taps, gap lengths.
package pq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      MODE_FILL   = 2'd0,
      MODE_DRAIN  = 2'd1,
      MODE_RANDOM = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      OP_ENQ,
      OP_DEQ,
      OP_REP,
      OP_SKIP
   } op_e;

   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int GAP_SHORT = 2;

   function automatic int gap_enq(input int qs);
      int g;
      g = $clog2(qs);
      return (g < 1) ? 1 : g;
   endfunction

   // Requested operation before full/empty skipping
   function automatic op_e pick_op(input mode_e m, input logic [1:0] sel);
      op_e op;
      op = OP_ENQ;
      unique case (m)
         MODE_FILL:  op = OP_ENQ;
         MODE_DRAIN: op = OP_DEQ;
         default: begin
            unique case (sel)
               2'b01:   op = OP_DEQ;
               2'b10:   op = OP_REP;
               default: op = OP_ENQ;
            endcase
         end
      endcase
      return op;
   endfunction

endpackage

// File: rtl/pq_lfsr.sv
// 16-bit Galois LFSR stepping once per enabled cycle.
// Reset loads SEED, which must be nonzero.
module pq_lfsr
   import pq_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] value
);

   // Shift right, folding the taps in when bit 0 falls out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         value <= SEED;
      else if (en)
         value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0);
   end

endmodule

// File: rtl/pq_initiator.sv
// Traffic initiator and checker for a priority queue.
// Issues budgeted FILL/DRAIN/RANDOM ops and counts flag/order errors.
module pq_initiator
   import pq_pkg::*;
#(
   parameter int          QUEUE_SIZE = 7,
   parameter int          DATA_WIDTH = 16,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                              i_CLK,
   input  logic                              i_RSTn,
   input  logic                              i_start,
   input  logic [1:0]                        i_mode,
   input  logic [7:0]                        i_num_ops,
   output logic                              o_wrt,
   output logic                              o_read,
   output logic [DATA_WIDTH-1:0]             o_data,
   input  logic                              i_full,
   input  logic                              i_empty,
   input  logic [DATA_WIDTH-1:0]             i_data,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [7:0]                        o_err_count,
   output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count
);

   localparam int CW = $clog2(QUEUE_SIZE + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_SIZE);
   localparam logic [7:0] GAP_E = 8'(gap_enq(QUEUE_SIZE) - 1);
   localparam logic [7:0] GAP_S = 8'(GAP_SHORT - 1);

   state_e                state_q, state_d;
   mode_e                 mode_q;
   op_e                   kind, op;
   logic [7:0]            ops_q;
   logic [7:0]            gap_q;
   logic [15:0]           lfsr;
   logic                  lfsr_unused;
   logic                  issue;
   logic                  flag_err, order_err;
   logic                  prev_v;
   logic [DATA_WIDTH-1:0] prev_root;

   assign issue       = (state_q == ISSUE);
   assign lfsr_unused = ^lfsr[15:12];

   pq_lfsr #(.SEED(SEED)) u_lfsr (
      .clk   (i_CLK),
      .rst_n (i_RSTn),
      .en    (issue),
      .value (lfsr)
   );

   // Pick this cycle's op, demoting it to a skip on full/empty
   always_comb begin
      kind = pick_op(mode_q, lfsr[11:10]);
      op   = kind;
      if (kind == OP_ENQ ? i_full : i_empty)
         op = OP_SKIP;
   end

   // Flag and root-order checks against the shadow occupancy
   always_comb begin
      flag_err  = (i_full != (o_count == FULL_CNT)) ||
                  (i_empty != (o_count == '0));
      order_err = (op == OP_DEQ) && prev_v && (i_data > prev_root);
   end

   // Next state and request outputs
   always_comb begin
      state_d = state_q;
      o_wrt   = 1'b0;
      o_read  = 1'b0;
      o_data  = '0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_start)
               state_d = (i_num_ops == 8'd0) ? DONE : ISSUE;
         end
         ISSUE: begin
            o_busy  = 1'b1;
            o_wrt   = (op == OP_ENQ) || (op == OP_REP);
            o_read  = (op == OP_DEQ) || (op == OP_REP);
            if (op != OP_SKIP)
               o_data = DATA_WIDTH'(lfsr[9:0]);
            state_d = GAP;
         end
         GAP: begin
            o_busy = 1'b1;
            if (gap_q == 8'd0)
               state_d = (ops_q == 8'd0) ? DONE : ISSUE;
         end
         DONE: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Run parameters, budget and gap counter
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         mode_q <= MODE_FILL;
         ops_q  <= 8'd0;
         gap_q  <= 8'd0;
      end else begin
         if (state_q == IDLE && i_start) begin
            mode_q <= mode_e'(i_mode);
            ops_q  <= i_num_ops;
         end
         if (issue) begin
            ops_q <= ops_q - 8'd1;
            gap_q <= (op == OP_ENQ) ? GAP_E : GAP_S;
         end else if (state_q == GAP && gap_q != 8'd0) begin
            gap_q <= gap_q - 8'd1;
         end
      end
   end

   // Shadow occupancy, error counter and dequeue history
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         o_count     <= '0;
         o_err_count <= 8'd0;
         prev_v      <= 1'b0;
         prev_root   <= '0;
      end else if (issue) begin
         if (op == OP_ENQ && o_count != FULL_CNT)
            o_count <= o_count + 1'b1;
         else if (op == OP_DEQ && o_count != '0)
            o_count <= o_count - 1'b1;
         if ((flag_err || order_err) && o_err_count != 8'hFF)
            o_err_count <= o_err_count + 8'd1;
         if (op == OP_DEQ) begin
            prev_v    <= 1'b1;
            prev_root <= i_data;
         end else if (op == OP_ENQ || op == OP_REP) begin
            prev_v <= 1'b0;
         end
      end
   end

endmodule
